serial_adder: RTL
=================

Name: serial_adder

Overview:
Parametrised bit-serial adder/subtractor. It is the sequential successor to the team's single-bit half adder. A start pulse captures two WIDTH-bit operands. The block then processes one bit per clock, LSB first, through a single full-adder cell with a registered carry, and reports sum, carry-out and signed overflow with a one-cycle done pulse. It sits behind switch/button inputs or a register interface, and drives LEDs or downstream logic.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
sub  input  1  0 = a+b, 1 = a-b; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse when result registers update
sum  output  WIDTH  result, held until next completion
carry_out  output  1  final carry (add: unsigned carry; sub: 1 = no borrow)
overflow  output  1  signed two's-complement overflow of the last operation

Behaviour:
- Reset (async, active-high):
  - state = IDLE.
  - Clears: sum = 0, carry_out = 0, overflow = 0, busy = 0, done = 0, internal shift registers, carry flop and bit counter.
  - Takes effect immediately, including mid-operation; any in-flight operation is discarded with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE -> SHIFT on a clock edge with start = 1. At that edge:
  - opA <= a.
  - opB <= (sub ? ~b : b).
  - carry <= sub.
  - cnt <= 0.
  - acc <= 0.
- SHIFT, each edge:
  - s = opA[0] ^ opB[0] ^ carry.
  - c = majority(opA[0], opB[0], carry).
  - acc <= {s, acc[WIDTH-1:1]}.
  - opA and opB shift right by 1.
  - carry <= c.
  - cnt <= cnt + 1.
  - On the edge processing bit WIDTH-1 (cnt == WIDTH-1):
    - Record cin_msb = carry (the carry into the MSB).
    - Write result registers: sum <= final acc including s; carry_out <= c; overflow <= cin_msb ^ c.
    - state <= DONE.
- DONE: done = 1 for exactly this one cycle, then IDLE on the next edge unconditionally.
- busy = 1 exactly in SHIFT. done = 1 exactly in DONE. Both are decoded from registered state (glitch-free).
- Latency: start sampled at edge E0; done is high in the cycle after edge E_WIDTH, i.e. WIDTH+1 clocks after E0. Throughput is one operation per WIDTH+2 clocks.
- Input sampling and hold:
  - start is ignored in SHIFT and DONE; no queuing.
  - a, b and sub may change freely after the sampling edge.
- sum, carry_out and overflow change only on the DONE-entry edge (or reset). They are stable otherwise, including throughout a following operation.
- Width rules:
  - cnt is clog2(WIDTH)+1 bits wide.
  - WIDTH = 1 is legal: SHIFT lasts one edge. With sub = 0 the result equals the half-adder pair sum = a^b, carry_out = a&b, when the carry-in is 0.
- Subtraction is two's complement via inverted B and carry-in = 1. Wrap-around is modulo 2^WIDTH.
- Simultaneous start and rst: rst wins.

Test Plan:
1. WIDTH=8, add 0x0F+0x01 -> sum=0x10, carry_out=0, overflow=0; busy high 8 cycles; done pulses exactly 9 clocks after the start edge, width 1.
2. WIDTH=8, add 0xFF+0x01 -> sum=0x00, carry_out=1, overflow=0. Then add 0x7F+0x01 -> sum=0x80, carry_out=0, overflow=1.
3. WIDTH=8, sub 0x05-0x07 -> sum=0xFE, carry_out=0, overflow=0. Then sub 0x80-0x01 -> sum=0x7F, carry_out=1, overflow=1.
4. WIDTH=8, start 0x10+0x20, then pulse start with 0xAA+0x55 at cycle 3 of SHIFT -> second request ignored; result 0x30; no second done; sum holds 0x30 until the next accepted operation completes.
5. Reset mid-operation: start 0x12+0x34, assert rst at cycle 4 of SHIFT -> immediately busy=0, done=0, sum=0, carry_out=0, overflow=0, state IDLE. A fresh start of 0x01+0x01 then yields sum=0x02 after 9 clocks.
6. WIDTH=1 build, all four a/b combinations with sub=0 -> (sum, carry_out) = (0,0), (1,0), (1,0), (0,1); done 2 clocks after each start.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial add/subtract of two WIDTH-bit operands, LSB first, one full-adder cell.
// Latency: start accepted at edge E0, result registers load at edge E_WIDTH, done high the cycle after.
// Backpressure: none; start is only honoured in IDLE, requests in SHIFT/DONE are dropped, not queued.
//
// Ports:
//   clk, rst              clock (rising edge) and asynchronous active-high reset
//   start, sub, a, b      request pulse, op select (0 = a+b, 1 = a-b), operands; sampled together in IDLE
//   busy                  high while bits are being processed
//   done                  one-cycle pulse when sum/carry_out/overflow have just been updated
//   sum, carry_out        result and final carry (for subtract, 1 means no borrow)
//   overflow              signed two's-complement overflow of the last operation
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_nxt;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             s;
   logic             c;
   logic             last;

   // single full-adder cell on the current LSBs
   assign s    = opa[0] ^ opb[0] ^ carry;
   assign c    = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);
   assign last = (cnt == CW'(WIDTH - 1));

   // new sum bit enters at the top; written this way so WIDTH = 1 needs no special case
   always_comb begin
      acc_nxt            = acc >> 1;
      acc_nxt[WIDTH-1]   = s;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (last)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opa       <= '0;
         opb       <= '0;
         acc       <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
         sum       <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  opa   <= a;
                  // subtract as a + ~b + 1: the +1 rides in on the initial carry
                  opb   <= sub ? ~b : b;
                  carry <= sub;
                  cnt   <= '0;
                  acc   <= '0;
               end
            end
            SHIFT: begin
               acc   <= acc_nxt;
               opa   <= opa >> 1;
               opb   <= opb >> 1;
               carry <= c;
               cnt   <= cnt + 1'b1;
               if (last) begin
                  sum       <= acc_nxt;
                  carry_out <= c;
                  // carry into the MSB differs from carry out of it exactly on signed overflow
                  overflow  <= carry ^ c;
               end
            end
            default: ;
         endcase
      end
   end

   // decoded straight from the state register so both are glitch-free
   assign busy = (state == SHIFT);
   assign done = (state == DONE);

endmodule
